seg_display_mux: RTL and testbench
==================================

SEG_DISPLAY_MUX -- requirements
Module: seg_display_mux

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clk cycles per digit slot; legal range 2 or more.
REQ-002 Parameter BLINK_FRAMES, default 100: full 6-digit frames per blink half-period; legal range 1 or more.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 sec  input  6  seconds, binary, from the time-keeping core.
REQ-006 min  input  6  minutes, binary.
REQ-007 hr  input  5  hours, binary.
REQ-008 mode_sel  input  2  00 clock, 01 stopwatch, 10 timer, 11 invalid.
REQ-009 alarm_flag  input  1  alarm active, level.
REQ-010 timer_done  input  1  timer expired, level.
REQ-011 an  output  6  digit enables, active-low; bit n drives digit n.
REQ-012 seg  output  7  segments, active-low, bit order {g,f,e,d,c,b,a}.
REQ-013 dp  output  1  decimal point, active-low.
REQ-014 frame_tick  output  1  one-cycle pulse when digit 5 slot ends.

Function
REQ-015 Prescaler shall count 0..SCAN_DIV-1 and wrap; slot tick = prescaler at SCAN_DIV-1.
REQ-016 Digit index shall advance by 1 on each slot tick and wrap 5 to 0.
REQ-017 Digit map: 0 sec ones, 1 sec tens, 2 min ones, 3 min tens, 4 hr ones, 5 hr tens.
REQ-018 sec/min/hr/mode_sel shall be captured into a snapshot only on a slot tick with index 5, so a frame never tears.
REQ-019 Each field shall be split into tens = v/10 and ones = v mod 10 from the snapshot.
REQ-020 Glyphs: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, dash=0111111.
REQ-021 A field out of range (sec>59, min>59, hr>23) shall show dash on both of its digits.
REQ-022 If snapshot mode is 11, all six digits shall show dash and dp shall be off.
REQ-023 dp shall be low on digits 2 and 4 in modes 00 and 01, and on digit 2 only in mode 10.
REQ-024 an, seg, dp and frame_tick shall be registered; outputs reflect the new digit index one clk after the slot tick.
REQ-025 Exactly one an bit shall be low at any time outside blanking and reset.
REQ-026 frame_tick shall be high for exactly one cycle, in the cycle after each index-5 slot tick.
REQ-027 Blink: while alarm_flag OR timer_done is high, a frame counter shall count frame ticks and toggle blink_phase every BLINK_FRAMES frames.
REQ-028 While blink_phase is 1, an shall be 111111, with seg and dp don't-care.
REQ-029 When alarm_flag and timer_done are both low, the frame counter and blink_phase shall clear on the next clk, and the display shall be unblanked from the following cycle.
REQ-030 alarm_flag and timer_done shall be sampled every cycle and are not snapshotted.

Reset
REQ-031 While rst is high: prescaler 0, index 0, snapshot all 0 with mode 00, frame counter 0, blink_phase 0, an=111111, seg=1111111, dp=1, frame_tick=0.
REQ-032 At the first rising edge after rst falls, outputs shall be an=111110 and seg=1000000, so the first frame shows 00:00:00.
REQ-033 rst asserted mid-frame or mid-blink shall take effect immediately, with no wait for clk.

Verification (SCAN_DIV=4, BLINK_FRAMES=2)
REQ-034 Release reset with hr=12, min=34, sec=56, mode 00 -> first frame shows 00:00:00; second frame shows digits 0..5 = 6,5,4,3,2,1 with seg 0000010,0010010,0011001,0110000,0100100,1111001 and dp low on digits 2 and 4.
REQ-035 Change sec from 56 to 57 at prescaler=1 of digit 2 -> digits 0/1 of the current frame are unchanged; 57 appears only after the next frame_tick.
REQ-036 sec=60, hr=24, min=5 -> digits 0,1,4,5 show 0111111; digits 2,3 show 5 and 0.
REQ-037 mode 11 -> all digits show 0111111 with dp=1; mode 10 -> dp low only on digit 2.
REQ-038 Raise alarm_flag -> an=111111 from frame 3 through frame 4, visible again frames 5-6, and so on; drop alarm_flag while blanked -> visible within 2 clk.
REQ-039 Pulse rst for 1 ns mid-frame -> an=111111 and seg=1111111 immediately, with no clk edge, then the REQ-032 sequence follows.

Source files
------------

// File: rtl/seg_display_mux.sv
// seg_display_mux: six-digit multiplexed 7-segment driver with tear-free frame snapshot and alarm blink
`timescale 1ns/1ps
module seg_display_mux #(
  parameter int SCAN_DIV = 1000,
  parameter int BLINK_FRAMES = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic [4:0] hr,
  input  logic [1:0] mode_sel,
  input  logic       alarm_flag,
  input  logic       timer_done,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = $clog2(BLINK_FRAMES) + 1;
  localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] F_LAST = FW'(BLINK_FRAMES - 1);
  logic [PW-1:0] r_presc;
  logic [2:0]    r_idx;
  logic [5:0]    r_sec, r_min;
  logic [4:0]    r_hr;
  logic [1:0]    r_mode;
  logic [FW-1:0] r_fcnt;
  logic          r_blink;
  logic          w_tick, w_fend, w_active, w_nblink, w_bad, w_dp;
  logic [2:0]    w_nidx;
  logic [5:0]    w_sec, w_min, w_val, w_an;
  logic [4:0]    w_hr;
  logic [1:0]    w_mode;
  logic [3:0]    w_digit;
  logic [6:0]    w_glyph;
  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction
  // Outputs are computed from the next index and next snapshot so the registered digit lines up with its slot
  always_comb begin
    w_tick   = r_presc == P_LAST;
    w_fend   = w_tick && r_idx == 3'd5;
    w_nidx   = w_tick ? (r_idx == 3'd5 ? 3'd0 : r_idx + 3'd1) : r_idx;
    w_sec    = w_fend ? sec : r_sec;
    w_min    = w_fend ? min : r_min;
    w_hr     = w_fend ? hr : r_hr;
    w_mode   = w_fend ? mode_sel : r_mode;
    w_active = alarm_flag | timer_done;
    w_nblink = w_active && (w_fend && r_fcnt == F_LAST ? ~r_blink : r_blink);
    w_val    = w_nidx[2] ? {1'b0, w_hr} : w_nidx[1] ? w_min : w_sec;
    w_bad    = w_mode == 2'b11 || (w_nidx[2] ? w_hr > 5'd23 : w_val > 6'd59);
    w_digit  = w_nidx[0] ? 4'(w_val / 6'd10) : 4'(w_val % 6'd10);
    w_glyph  = w_bad ? 7'b0111111 : glyph(w_digit);
    w_dp     = ~(w_mode != 2'b11 && (w_nidx == 3'd2 || (w_nidx == 3'd4 && !w_mode[1])));
    w_an     = w_nblink ? 6'h3f : ~(6'd1 << w_nidx);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc    <= '0;
      r_idx      <= '0;
      r_sec      <= '0;
      r_min      <= '0;
      r_hr       <= '0;
      r_mode     <= '0;
      r_fcnt     <= '0;
      r_blink    <= 1'b0;
      an         <= 6'h3f;
      seg        <= 7'h7f;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      r_presc    <= w_tick ? '0 : r_presc + 1'b1;
      r_idx      <= w_nidx;
      r_sec      <= w_sec;
      r_min      <= w_min;
      r_hr       <= w_hr;
      r_mode     <= w_mode;
      r_fcnt     <= !w_active ? '0 : w_fend ? (r_fcnt == F_LAST ? '0 : r_fcnt + 1'b1) : r_fcnt;
      r_blink    <= w_nblink;
      an         <= w_an;
      seg        <= w_glyph;
      dp         <= w_dp;
      frame_tick <= w_fend;
    end
  end
endmodule

// File: tb/tb_seg_display_mux.sv
// tb_seg_display_mux: frame-level reference model plus directed vectors for seg_display_mux
`timescale 1ns/1ps
module tb_seg_display_mux;
  localparam int SD = 4, BF = 2, FL = 6 * SD;
  localparam logic [6:0] GL [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                     7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  localparam logic [6:0] DASH = 7'b0111111;
  logic clk = 1'b0, rst = 1'b1;
  logic [5:0] sec, min;
  logic [4:0] hr;
  logic [1:0] mode_sel;
  logic alarm_flag, timer_done;
  logic [5:0] an;
  logic [6:0] seg;
  logic dp, frame_tick;
  int total = 0, bad = 0;
  int m_k, m_sec, m_min, m_hr, m_mode, m_fa;
  int d, v, lim, dig;
  logic blank, e_dp;
  logic [5:0] e_an;
  logic [6:0] e_seg;
  always #5 clk = ~clk;
  seg_display_mux #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .sec(sec), .min(min), .hr(hr), .mode_sel(mode_sel),
    .alarm_flag(alarm_flag), .timer_done(timer_done),
    .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
  );
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h k=%0d t=%0t", nm, got, exp, m_k, $time);
    end
  endtask
  task automatic wait_k(input int t);
    int n = 0;
    while (m_k < t && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (m_k != t) begin
      total++;
      bad++;
      $display("FAIL wait_k got=%0d exp=%0d", m_k, t);
    end
  endtask
  // m_k counts edges since reset; a frame ends every FL edges and the snapshot is taken there
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_k <= 0; m_sec <= 0; m_min <= 0; m_hr <= 0; m_mode <= 0; m_fa <= 0;
    end else begin
      m_k <= m_k + 1;
      if ((m_k + 1) % FL == 0) begin
        m_sec <= int'(sec); m_min <= int'(min); m_hr <= int'(hr); m_mode <= int'(mode_sel);
      end
      m_fa <= !(alarm_flag || timer_done) ? 0 : ((m_k + 1) % FL == 0 ? m_fa + 1 : m_fa);
    end
  end
  always @(negedge clk) begin
    if (rst || m_k == 0) begin
      chk("c_rst_an", 32'(an), 32'(6'h3f));
      chk("c_rst_seg", 32'(seg), 32'(7'h7f));
      chk("c_rst_dp", 32'(dp), 32'(1'b1));
      chk("c_rst_ft", 32'(frame_tick), 32'(1'b0));
    end else begin
      d = (m_k / SD) % 6;
      blank = ((m_fa / BF) % 2) == 1;
      v = d < 2 ? m_sec : d < 4 ? m_min : m_hr;
      lim = d < 4 ? 59 : 23;
      dig = d % 2 == 1 ? v / 10 : v % 10;
      e_an = blank ? 6'h3f : ~(6'd1 << d);
      e_seg = (m_mode == 3 || v > lim) ? DASH : GL[4'(dig)];
      e_dp = !((d == 2 && m_mode != 3) || (d == 4 && m_mode < 2));
      chk("c_an", 32'(an), 32'(e_an));
      if (!blank) begin
        chk("c_seg", 32'(seg), 32'(e_seg));
        chk("c_dp", 32'(dp), 32'(e_dp));
      end
      chk("c_ft", 32'(frame_tick), 32'(m_k % FL == 0));
    end
  end
  initial begin
    sec = 56; min = 34; hr = 12; mode_sel = 0; alarm_flag = 0; timer_done = 0;
    repeat (2) @(negedge clk);
    chk("rst_an", 32'(an), 32'(6'b111111));
    chk("rst_seg", 32'(seg), 32'(7'b1111111));
    chk("rst_dp", 32'(dp), 32'(1'b1));
    rst = 0;
    wait_k(1);  chk("first_an", 32'(an), 32'(6'b111110)); chk("first_seg", 32'(seg), 32'(7'b1000000));
    wait_k(20); chk("f0d5_an", 32'(an), 32'(6'b011111)); chk("f0d5_seg", 32'(seg), 32'(7'b1000000));
    wait_k(24); chk("f1_ft", 32'(frame_tick), 32'(1'b1)); chk("f1d0_seg", 32'(seg), 32'(7'b0000010));
    wait_k(25); chk("f1_ft_off", 32'(frame_tick), 32'(1'b0));
    wait_k(28); chk("f1d1_seg", 32'(seg), 32'(7'b0010010));
    wait_k(32); chk("f1d2_seg", 32'(seg), 32'(7'b0011001)); chk("f1d2_dp", 32'(dp), 32'(1'b0));
    wait_k(36); chk("f1d3_seg", 32'(seg), 32'(7'b0110000)); chk("f1d3_dp", 32'(dp), 32'(1'b1));
    wait_k(40); chk("f1d4_seg", 32'(seg), 32'(7'b0100100)); chk("f1d4_dp", 32'(dp), 32'(1'b0));
    wait_k(44); chk("f1d5_seg", 32'(seg), 32'(7'b1111001)); chk("f1d5_an", 32'(an), 32'(6'b011111));
    wait_k(57); sec = 57;
    wait_k(72); chk("sec57_seg", 32'(seg), 32'(7'b1111000));
    wait_k(73); sec = 60; hr = 24; min = 5;
    wait_k(96); chk("secbad_d0", 32'(seg), 32'(DASH));
    wait_k(97); sec = 56; min = 34; hr = 12; mode_sel = 3;
    wait_k(104); chk("min5_d2", 32'(seg), 32'(7'b0010010));
    wait_k(108); chk("min5_d3", 32'(seg), 32'(7'b1000000));
    wait_k(112); chk("hrbad_d4", 32'(seg), 32'(DASH));
    wait_k(116); chk("hrbad_d5", 32'(seg), 32'(DASH));
    wait_k(121); mode_sel = 2;
    wait_k(128); chk("m3_seg", 32'(seg), 32'(DASH)); chk("m3_dp", 32'(dp), 32'(1'b1));
    wait_k(145); alarm_flag = 1;
    wait_k(152); chk("m2_d2_seg", 32'(seg), 32'(7'b0011001)); chk("m2_d2_dp", 32'(dp), 32'(1'b0));
    wait_k(160); chk("m2_d4_seg", 32'(seg), 32'(7'b0100100)); chk("m2_d4_dp", 32'(dp), 32'(1'b1));
    wait_k(191); chk("pre_blank_an", 32'(an), 32'(6'b011111));
    wait_k(192); chk("blank_start", 32'(an), 32'(6'b111111));
    wait_k(239); chk("blank_end", 32'(an), 32'(6'b111111));
    wait_k(240); chk("unblank", 32'(an), 32'(6'b111110));
    wait_k(288); chk("reblank", 32'(an), 32'(6'b111111));
    wait_k(290); alarm_flag = 0;
    wait_k(291); chk("alarm_drop", 32'(an), 32'(6'b111110));
    wait_k(300); timer_done = 1;
    wait_k(336); chk("timer_blank", 32'(an), 32'(6'b111111));
    wait_k(340); timer_done = 0;
    wait_k(341); chk("timer_drop", 32'(an), 32'(6'b111101));
    wait_k(350);
    #2 rst = 1;
    #0.5;
    chk("async_an", 32'(an), 32'(6'b111111));
    chk("async_seg", 32'(seg), 32'(7'b1111111));
    #0.5 rst = 0;
    wait_k(1); chk("rerst_an", 32'(an), 32'(6'b111110)); chk("rerst_seg", 32'(seg), 32'(7'b1000000));
    wait_k(30);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
